// File: rtl/icb_msp_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : icb_msp_initiator
//  Purpose  : Frame sequencer that feeds a MEL accelerator over ICB. It packs
//             pairs of 16-bit samples into 32-bit words and writes N_WORDS of
//             them to BASE_ADDR. It then reads N_RESULTS words from
//             BASE_ADDR+4 and forwards each one on a result stream. Only one
//             ICB command is outstanding at any time.
//  Options  : `define ICB_MSP_INIT_TIMEOUT_EN adds a response watchdog.
//             When it fires, the frame aborts with err after TIMEOUT_CYC
//             cycles without icb_rsp_valid.
//  Ports    : clk, rst (sync, active-high)
//             start                       - one-cycle frame start (IDLE only)
//             s_valid/s_ready/s_data[15:0] - sample stream in
//             m_valid/m_ready/m_data[31:0] - result stream out
//             icb_cmd_*                   - ICB command channel
//             icb_rsp_*                   - ICB response channel
//             busy, done, err             - status (done = 1-cycle pulse,
//                                           err = sticky until rst/start)
//  Revision : 1.0 - initial release
// ============================================================================
module icb_msp_initiator #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          N_WORDS     = 240,
  parameter int          N_RESULTS   = 40,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        icb_cmd_valid,
  input  logic        icb_cmd_ready,
  output logic        icb_cmd_read,
  output logic [31:0] icb_cmd_addr,
  output logic [31:0] icb_cmd_wdata,
  output logic [3:0]  icb_cmd_wmask,
  input  logic        icb_rsp_valid,
  output logic        icb_rsp_ready,
  input  logic [31:0] icb_rsp_rdata,
  input  logic        icb_rsp_err,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int WC_W = $clog2(N_WORDS + 1);
  localparam int RC_W = $clog2(N_RESULTS + 1);
  localparam logic [WC_W-1:0] WR_MAX  = WC_W'(N_WORDS);
  localparam logic [WC_W-1:0] WR_LAST = WC_W'(N_WORDS - 1);
  localparam logic [RC_W-1:0] RD_MAX  = RC_W'(N_RESULTS);
  localparam logic [RC_W-1:0] RD_LAST = RC_W'(N_RESULTS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PACK   = 3'd1,
    S_WR_CMD = 3'd2,
    S_WR_RSP = 3'd3,
    S_RD_CMD = 3'd4,
    S_RD_RSP = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       wdata_q;
  logic              half_q;      // 1 once the low half-word has been captured
  logic [WC_W-1:0]   wr_cnt;
  logic [RC_W-1:0]   rd_cnt;
  logic              err_q;
  logic              done_q;

  logic              start_acc;
  logic              wr_rsp_hs;
  logic              rd_rsp_hs;
  logic              rsp_err_hs;
  logic              in_rsp;
  logic              tmo_hit;

  assign start_acc  = (state == S_IDLE) && start;
  assign wr_rsp_hs  = (state == S_WR_RSP) && icb_rsp_valid;            // ready is 1 here
  assign rd_rsp_hs  = (state == S_RD_RSP) && icb_rsp_valid && m_ready; // ready follows m_ready
  assign rsp_err_hs = (wr_rsp_hs || rd_rsp_hs) && icb_rsp_err;
  assign in_rsp     = (state == S_WR_RSP) || (state == S_RD_RSP);

`ifdef ICB_MSP_INIT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);

  logic [TMO_W-1:0] tmo_cnt;

  // The counter is held at zero outside the response states. This makes it
  // start from zero on every entry. It also stays at zero while a response is
  // present but stalled by m_ready.
  always_ff @(posedge clk) begin
    if (rst || !in_rsp || icb_rsp_valid) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = in_rsp && !icb_rsp_valid && (tmo_cnt == TMO_LAST);
`else
  // Without the watchdog, response states wait forever.
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      wdata_q <= '0;
      half_q  <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= rd_rsp_hs && !icb_rsp_err && (rd_cnt >= RD_LAST);

      if (start_acc) begin
        err_q <= 1'b0;
      end else if (rsp_err_hs || tmo_hit) begin
        err_q <= 1'b1;
      end

      if (start_acc) begin
        wr_cnt <= '0;
        rd_cnt <= '0;
        half_q <= 1'b0;
      end else begin
        if ((state == S_PACK) && s_valid) begin
          if (!half_q) begin
            wdata_q[15:0] <= s_data;
            half_q        <= 1'b1;
          end else begin
            wdata_q[31:16] <= s_data;
            half_q         <= 1'b0;
          end
        end
        if (wr_rsp_hs && (wr_cnt != WR_MAX)) begin
          wr_cnt <= wr_cnt + 1'b1;
        end
        if (rd_rsp_hs && (rd_cnt != RD_MAX)) begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_PACK;
      end
      S_PACK: begin
        if (s_valid && half_q) state_nxt = S_WR_CMD;
      end
      S_WR_CMD: begin
        if (icb_cmd_ready) state_nxt = S_WR_RSP;
      end
      S_WR_RSP: begin
        if (icb_rsp_valid) begin
          if (icb_rsp_err)          state_nxt = S_IDLE;
          else if (wr_cnt >= WR_LAST) state_nxt = S_RD_CMD;
          else                      state_nxt = S_PACK;
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_RD_CMD: begin
        if (icb_cmd_ready) state_nxt = S_RD_RSP;
      end
      S_RD_RSP: begin
        if (rd_rsp_hs) begin
          if (icb_rsp_err || (rd_cnt >= RD_LAST)) state_nxt = S_IDLE;
          else                                    state_nxt = S_RD_CMD;
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs. Command fields are driven only in the command states. This keeps
  // them constant from the registers for the whole wait for icb_cmd_ready.
  // --------------------------------------------------------------------------
  always_comb begin
    s_ready       = 1'b0;
    m_valid       = 1'b0;
    m_data        = '0;
    icb_cmd_valid = 1'b0;
    icb_cmd_read  = 1'b0;
    icb_cmd_addr  = '0;
    icb_cmd_wdata = '0;
    icb_cmd_wmask = 4'h0;
    icb_rsp_ready = 1'b0;
    unique case (state)
      S_PACK: s_ready = 1'b1;
      S_WR_CMD: begin
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = BASE_ADDR;
        icb_cmd_wdata = wdata_q;
        icb_cmd_wmask = 4'hF;
      end
      S_WR_RSP: icb_rsp_ready = 1'b1;
      S_RD_CMD: begin
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = BASE_ADDR + 32'd4;
      end
      S_RD_RSP: begin
        // Zero-latency pass-through of the response to the result stream.
        m_valid       = icb_rsp_valid;
        m_data        = icb_rsp_rdata;
        icb_rsp_ready = m_ready;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_icb_msp_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icb_msp_initiator
//  Purpose  : Directed self-checking bench for icb_msp_initiator. It uses
//             N_WORDS=2, N_RESULTS=3 and TIMEOUT_CYC=8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icb_msp_initiator;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready = 1'b0;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid = 1'b0;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata = '0;
  logic        icb_rsp_err = 1'b0;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int n_rd = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  icb_msp_initiator #(
    .BASE_ADDR  (BASE),
    .N_WORDS    (2),
    .N_RESULTS  (3),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .busy(busy), .done(done), .err(err)
  );

  // Count command handshakes and done pulses as they happen.
  always @(posedge clk) begin
    if (icb_cmd_valid && icb_cmd_ready) begin
      if (icb_cmd_read) n_rd <= n_rd + 1;
      else              n_wr <= n_wr + 1;
    end
    if (done) n_done <= n_done + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".busy"},    32'(busy), 0);
    check_eq({tag, ".done"},    32'(done), 0);
    check_eq({tag, ".s_ready"}, 32'(s_ready), 0);
    check_eq({tag, ".cmd_vld"}, 32'(icb_cmd_valid), 0);
    check_eq({tag, ".rsp_rdy"}, 32'(icb_rsp_ready), 0);
    check_eq({tag, ".m_valid"}, 32'(m_valid), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    s_valid = 1'b1;
    s_data  = a;
    step();
    s_data  = b;
    step();
    s_valid = 1'b0;
    #1;
  endtask

  // One write word: pack, command with cmd_wait stall cycles, response.
  task automatic write_word(input logic [15:0] a, input logic [15:0] b,
                            input int cmd_wait, input logic rsp_e);
    logic [31:0] exp_w;
    exp_w = {b, a};
    check_eq("pack.s_ready", 32'(s_ready), 1);
    push_pair(a, b);
    check_eq("wr.cmd_valid", 32'(icb_cmd_valid), 1);
    check_eq("wr.read", 32'(icb_cmd_read), 0);
    for (int i = 0; i < cmd_wait; i++) begin
      check_eq("wr.addr", icb_cmd_addr, BASE);
      check_eq("wr.wdata", icb_cmd_wdata, exp_w);
      check_eq("wr.wmask", 32'(icb_cmd_wmask), 32'hF);
      step();
    end
    check_eq("wr.wdata_final", icb_cmd_wdata, exp_w);
    icb_cmd_ready = 1'b1;
    step();
    icb_cmd_ready = 1'b0;
    #1;
    check_eq("wrrsp.cmd_valid", 32'(icb_cmd_valid), 0);
    check_eq("wrrsp.rsp_ready", 32'(icb_rsp_ready), 1);
    icb_rsp_valid = 1'b1;
    icb_rsp_err   = rsp_e;
    step();
    icb_rsp_valid = 1'b0;
    icb_rsp_err   = 1'b0;
    #1;
  endtask

  task automatic read_word(input logic [31:0] data, input int m_wait);
    check_eq("rd.cmd_valid", 32'(icb_cmd_valid), 1);
    check_eq("rd.read", 32'(icb_cmd_read), 1);
    check_eq("rd.addr", icb_cmd_addr, BASE + 32'd4);
    check_eq("rd.wmask", 32'(icb_cmd_wmask), 0);
    icb_cmd_ready = 1'b1;
    step();
    icb_cmd_ready = 1'b0;
    icb_rsp_valid = 1'b1;
    icb_rsp_rdata = data;
    m_ready       = 1'b0;
    #1;
    check_eq("rdrsp.cmd_valid", 32'(icb_cmd_valid), 0);
    for (int i = 0; i < m_wait; i++) begin
      check_eq("rdrsp.stall_rsp_ready", 32'(icb_rsp_ready), 0);
      check_eq("rdrsp.stall_m_valid", 32'(m_valid), 1);
      check_eq("rdrsp.stall_m_data", m_data, data);
      step();
    end
    m_ready = 1'b1;
    #1;
    check_eq("rdrsp.rsp_ready", 32'(icb_rsp_ready), 1);
    check_eq("rdrsp.m_data", m_data, data);
    step();
    icb_rsp_valid = 1'b0;
    m_ready       = 1'b0;
    #1;
  endtask

  initial begin
    int wr0, rd0, dn0;

    // ---------------- reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check_idle_outputs("reset");
    check_eq("reset.err", 32'(err), 0);

    // ---------------- full frame with command and result-stream stalls
    do_start();
    check_eq("start.busy", 32'(busy), 1);
    write_word(16'h0001, 16'h0002, 5, 1'b0);
    check_eq("f1.writes_after_1", 32'(n_wr), 1);
    write_word(16'h0003, 16'h0004, 0, 1'b0);
    check_eq("f1.writes", 32'(n_wr), 2);
    read_word(32'hDEAD_BEEF, 4);
    read_word(32'h1111_1111, 0);
    check_eq("f1.done_early", 32'(n_done), 0);
    read_word(32'h2222_2222, 0);
    check_eq("f1.done", 32'(done), 1);
    check_eq("f1.busy_end", 32'(busy), 0);
    check_eq("f1.reads", 32'(n_rd), 3);
    step();
    check_eq("f1.done_pulse_len", 32'(done), 0);
    check_eq("f1.done_count", 32'(n_done), 1);
    check_eq("f1.err", 32'(err), 0);

    // ---------------- error on second write response
    wr0 = n_wr; rd0 = n_rd; dn0 = n_done;
    do_start();
    write_word(16'h0011, 16'h0022, 0, 1'b0);
    write_word(16'h0033, 16'h0044, 0, 1'b1);
    check_eq("err.err", 32'(err), 1);
    check_eq("err.busy", 32'(busy), 0);
    repeat (3) step();
    check_eq("err.no_read", 32'(n_rd - rd0), 0);
    check_eq("err.writes", 32'(n_wr - wr0), 2);
    check_eq("err.no_done", 32'(n_done - dn0), 0);
    check_eq("err.sticky", 32'(err), 1);
    do_start();
    check_eq("err.clr_on_start", 32'(err), 0);

    // ---------------- reset mid-PACK
    s_valid = 1'b1;
    s_data  = 16'hAAAA;
    step();
    s_valid = 1'b0;
    rst = 1'b1;
    step();
    check_idle_outputs("midrst");
    check_eq("midrst.err", 32'(err), 0);
    rst = 1'b0;
    do_start();
    push_pair(16'h0005, 16'h0006);
    check_eq("midrst.repack", icb_cmd_wdata, 32'h0006_0005);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;

    // ---------------- missing write response
    do_start();
    push_pair(16'h0007, 16'h0008);
    icb_cmd_ready = 1'b1;
    step();
    icb_cmd_ready = 1'b0;
    #1;
`ifdef ICB_MSP_INIT_TIMEOUT_EN
    repeat (7) step();
    check_eq("tmo.busy_before", 32'(busy), 1);
    check_eq("tmo.err_before", 32'(err), 0);
    step();
    check_eq("tmo.busy_after", 32'(busy), 0);
    check_eq("tmo.err_after", 32'(err), 1);
`else
    repeat (100) step();
    check_eq("notmo.busy", 32'(busy), 1);
    check_eq("notmo.rsp_ready", 32'(icb_rsp_ready), 1);
    check_eq("notmo.err", 32'(err), 0);
`endif
    check_eq("total_done", 32'(n_done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
